// File: rtl/pdp8_mem_arb_pkg.sv
// Shared types for the PDP-8 memory arbiter: state encodings, requester indices, latched access record.
package pdp8_mem_arb_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 12;
    localparam int NREQ   = 3;

    localparam int REQ_DMA0 = 0;
    localparam int REQ_DMA1 = 1;
    localparam int REQ_CPU  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } acc_t;

endpackage

// File: rtl/pdp8_arb_pick.sv
// Priority select dma0 > dma1 > cpu with a burst guard that lets a waiting CPU in after MAX_BURST DMA grants.
// Latency: combinational winner; burst_cnt updates on the grant edge. No backpressure: winner is only non-zero while idle.
module pdp8_arb_pick
    import pdp8_mem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            idle,
    output logic [NREQ-1:0] winner
);

    logic [7:0] burst_cnt;
    logic       guard;

    always_comb begin
        guard  = (MAX_BURST != 0) && (burst_cnt == 8'(MAX_BURST)) && req[REQ_CPU];
        winner = '0;
        if (idle) begin
            if (guard)               winner[REQ_CPU]  = 1'b1;
            else if (req[REQ_DMA0])  winner[REQ_DMA0] = 1'b1;
            else if (req[REQ_DMA1])  winner[REQ_DMA1] = 1'b1;
            else if (req[REQ_CPU])   winner[REQ_CPU]  = 1'b1;
        end
    end

    // The guard forces a CPU grant at the limit, so the count never passes MAX_BURST.
    always_ff @(posedge clk) begin
        if (reset || !req[REQ_CPU]) begin
            burst_cnt <= 8'd0;
        end else if (winner[REQ_CPU]) begin
            burst_cnt <= 8'd0;
        end else if ((MAX_BURST != 0) && (winner[REQ_DMA0] || winner[REQ_DMA1])) begin
            burst_cnt <= burst_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/pdp8_mem_arb.sv
// Shares the single pdp8_ram port between CPU and two data-break channels, one access at a time.
// Latency: request in idle cycle 0 -> strobes cycles 1..RAM_LAT, done pulse cycle RAM_LAT+1, next decision RAM_LAT+2.
// Backpressure: requesters hold read_req/write_req until their done pulse; losers simply keep waiting.
module pdp8_mem_arb
    import pdp8_mem_arb_pkg::*;
#(
    parameter int RAM_LAT   = 2,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_read_req,
    input  logic              cpu_write_req,
    input  logic [ADDR_W-1:0] cpu_ma,
    input  logic [DATA_W-1:0] cpu_in,
    output logic [DATA_W-1:0] cpu_out,
    output logic              cpu_done,

    input  logic              dma0_read_req,
    input  logic              dma0_write_req,
    input  logic [ADDR_W-1:0] dma0_ma,
    input  logic [DATA_W-1:0] dma0_in,
    output logic [DATA_W-1:0] dma0_out,
    output logic              dma0_done,

    input  logic              dma1_read_req,
    input  logic              dma1_write_req,
    input  logic [ADDR_W-1:0] dma1_ma,
    input  logic [DATA_W-1:0] dma1_in,
    output logic [DATA_W-1:0] dma1_out,
    output logic              dma1_done,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_out,
    input  logic [DATA_W-1:0] ram_data_in,
    output logic              ram_rd,
    output logic              ram_wr,

    output logic [NREQ-1:0]   grant,
    output logic              busy
);

    localparam logic [3:0] LAT_INIT = 4'(RAM_LAT - 1);

    arb_state_t        state, state_nx;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   win;
    logic [NREQ-1:0]   owner_q;
    acc_t              acc_q, acc_sel;
    logic [3:0]        lat_cnt;
    logic [DATA_W-1:0] out_q [NREQ];

    assign req[REQ_DMA0] = dma0_read_req | dma0_write_req;
    assign req[REQ_DMA1] = dma1_read_req | dma1_write_req;
    assign req[REQ_CPU]  = cpu_read_req  | cpu_write_req;

    pdp8_arb_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .idle   (state == ST_IDLE),
        .winner (win)
    );

    // write_req wins over read_req when a requester raises both.
    always_comb begin
        acc_sel = '0;
        if (win[REQ_DMA0])     acc_sel = '{wr: dma0_write_req, addr: dma0_ma, data: dma0_in};
        else if (win[REQ_DMA1]) acc_sel = '{wr: dma1_write_req, addr: dma1_ma, data: dma1_in};
        else if (win[REQ_CPU])  acc_sel = '{wr: cpu_write_req,  addr: cpu_ma,  data: cpu_in};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (|win)            state_nx = ST_ACCESS;
            ST_ACCESS: if (lat_cnt == 4'd0) state_nx = ST_DONE;
            ST_DONE:                        state_nx = ST_IDLE;
            default:                        state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= '0;
            acc_q   <= '0;
            lat_cnt <= 4'd0;
            for (int i = 0; i < NREQ; i++) out_q[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|win) begin
                        owner_q <= win;
                        acc_q   <= acc_sel;
                        lat_cnt <= LAT_INIT;
                    end
                end
                ST_ACCESS: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else if (!acc_q.wr) begin
                        for (int i = 0; i < NREQ; i++)
                            if (owner_q[i]) out_q[i] <= ram_data_in;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address and write data come straight from the latch, so they cannot move mid-access.
    assign ram_addr     = acc_q.addr;
    assign ram_data_out = acc_q.data;
    assign ram_rd       = (state == ST_ACCESS) && !acc_q.wr;
    assign ram_wr       = (state == ST_ACCESS) &&  acc_q.wr;

    assign busy  = (state != ST_IDLE);
    assign grant = busy ? owner_q : '0;

    assign cpu_done  = (state == ST_DONE) && owner_q[REQ_CPU];
    assign dma0_done = (state == ST_DONE) && owner_q[REQ_DMA0];
    assign dma1_done = (state == ST_DONE) && owner_q[REQ_DMA1];

    assign cpu_out  = out_q[REQ_CPU];
    assign dma0_out = out_q[REQ_DMA0];
    assign dma1_out = out_q[REQ_DMA1];

endmodule

// File: tb/tb_pdp8_mem_arb.sv
// Directed bench for pdp8_mem_arb with a behavioural 32Kx12 RAM and a second instance with the burst guard disabled.
module tb_pdp8_mem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read_req, cpu_write_req, dma0_read_req, dma0_write_req, dma1_read_req, dma1_write_req;
    logic [14:0] cpu_ma, dma0_ma, dma1_ma, ram_addr;
    logic [11:0] cpu_in, dma0_in, dma1_in, cpu_out, dma0_out, dma1_out;
    logic [11:0] ram_data_out, ram_data_in;
    logic        cpu_done, dma0_done, dma1_done, ram_rd, ram_wr, busy;
    logic [2:0]  grant;

    logic        d2_dma0_rd, d2_cpu_rd;
    logic [11:0] d2_cpu_out, d2_dma0_out, d2_dma1_out, d2_ram_data_out;
    logic        d2_cpu_done, d2_dma0_done, d2_dma1_done, d2_ram_rd, d2_ram_wr, d2_busy;
    logic [14:0] d2_ram_addr;
    logic [2:0]  d2_grant;

    int total = 0;
    int bad   = 0;

    logic [11:0] mem [0:32767];

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_data_out;
    assign ram_data_in = mem[ram_addr];

    pdp8_mem_arb #(.RAM_LAT(2), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_read_req(cpu_read_req), .cpu_write_req(cpu_write_req), .cpu_ma(cpu_ma), .cpu_in(cpu_in),
        .cpu_out(cpu_out), .cpu_done(cpu_done),
        .dma0_read_req(dma0_read_req), .dma0_write_req(dma0_write_req), .dma0_ma(dma0_ma), .dma0_in(dma0_in),
        .dma0_out(dma0_out), .dma0_done(dma0_done),
        .dma1_read_req(dma1_read_req), .dma1_write_req(dma1_write_req), .dma1_ma(dma1_ma), .dma1_in(dma1_in),
        .dma1_out(dma1_out), .dma1_done(dma1_done),
        .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .grant(grant), .busy(busy)
    );

    pdp8_mem_arb #(.RAM_LAT(2), .MAX_BURST(0)) dut2 (
        .clk(clk), .reset(reset),
        .cpu_read_req(d2_cpu_rd), .cpu_write_req(1'b0), .cpu_ma(15'o00200), .cpu_in(12'o0),
        .cpu_out(d2_cpu_out), .cpu_done(d2_cpu_done),
        .dma0_read_req(d2_dma0_rd), .dma0_write_req(1'b0), .dma0_ma(15'o00300), .dma0_in(12'o0),
        .dma0_out(d2_dma0_out), .dma0_done(d2_dma0_done),
        .dma1_read_req(1'b0), .dma1_write_req(1'b0), .dma1_ma(15'o0), .dma1_in(12'o0),
        .dma1_out(d2_dma1_out), .dma1_done(d2_dma1_done),
        .ram_addr(d2_ram_addr), .ram_data_out(d2_ram_data_out), .ram_data_in(12'o0),
        .ram_rd(d2_ram_rd), .ram_wr(d2_ram_wr), .grant(d2_grant), .busy(d2_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one access on a channel from an idle cycle; returns the done/out seen in the done cycle.
    task automatic run_access(input int ch, input logic wr, input logic [14:0] ma, input logic [11:0] din,
                              output logic done_s, output logic [11:0] out_s);
        if (ch == 0) begin dma0_write_req = wr; dma0_read_req = !wr; dma0_ma = ma; dma0_in = din; end
        else if (ch == 1) begin dma1_write_req = wr; dma1_read_req = !wr; dma1_ma = ma; dma1_in = din; end
        else begin cpu_write_req = wr; cpu_read_req = !wr; cpu_ma = ma; cpu_in = din; end
        repeat (3) tick;
        done_s = (ch == 0) ? dma0_done : (ch == 1) ? dma1_done : cpu_done;
        out_s  = (ch == 0) ? dma0_out  : (ch == 1) ? dma1_out  : cpu_out;
        {dma0_read_req, dma0_write_req, dma1_read_req, dma1_write_req, cpu_read_req, cpu_write_req} = '0;
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        total++; if ({ram_rd, ram_wr} !== 2'b00) begin bad++; $display("FAIL reset_strobes got %b exp 00", {ram_rd, ram_wr}); end
        total++; if (ram_addr !== 15'o0) begin bad++; $display("FAIL reset_addr got %o exp 0", ram_addr); end
        total++; if (ram_data_out !== 12'o0) begin bad++; $display("FAIL reset_wdata got %o exp 0", ram_data_out); end
        total++; if ({cpu_done, dma0_done, dma1_done} !== 3'b000) begin bad++; $display("FAIL reset_done got %b exp 000", {cpu_done, dma0_done, dma1_done}); end
        total++; if ({cpu_out, dma0_out, dma1_out} !== 36'd0) begin bad++; $display("FAIL reset_out got %o %o %o exp 0", cpu_out, dma0_out, dma1_out); end
        total++; if ({grant, busy} !== 4'b0000) begin bad++; $display("FAIL reset_grant got %b/%b exp 000/0", grant, busy); end
        total++; if ({d2_cpu_out, d2_dma0_out, d2_dma1_out, d2_ram_data_out, d2_ram_addr, d2_cpu_done,
                      d2_dma0_done, d2_dma1_done, d2_ram_rd, d2_ram_wr, d2_busy, d2_grant} !== '0) begin
            bad++; $display("FAIL reset_dut2 outputs not all zero busy=%b grant=%b", d2_busy, d2_grant);
        end
    endtask

    task automatic test_cpu_write_read;
        cpu_write_req = 1'b1; cpu_ma = 15'o00200; cpu_in = 12'o7402;
        tick;
        total++; if ({ram_wr, ram_rd} !== 2'b10) begin bad++; $display("FAIL cw_c1_strobe got wr=%b rd=%b exp 1/0", ram_wr, ram_rd); end
        total++; if ({grant, busy} !== 4'b1001) begin bad++; $display("FAIL cw_c1_grant got %b/%b exp 100/1", grant, busy); end
        total++; if ({ram_addr, ram_data_out} !== {15'o00200, 12'o7402}) begin bad++; $display("FAIL cw_c1_bus got %o %o exp 200 7402", ram_addr, ram_data_out); end
        tick;
        total++; if ({ram_wr, cpu_done} !== 2'b10) begin bad++; $display("FAIL cw_c2 got wr=%b done=%b exp 1/0", ram_wr, cpu_done); end
        tick;
        total++; if ({ram_wr, cpu_done, grant} !== 5'b01100) begin bad++; $display("FAIL cw_c3 got wr=%b done=%b grant=%b exp 0/1/100", ram_wr, cpu_done, grant); end
        total++; if (cpu_out !== 12'o0) begin bad++; $display("FAIL cw_out_unchanged got %o exp 0", cpu_out); end
        cpu_write_req = 1'b0;
        tick;
        total++; if ({busy, grant, cpu_done} !== 5'b00000) begin bad++; $display("FAIL cw_c4_idle got busy=%b grant=%b done=%b", busy, grant, cpu_done); end
        cpu_read_req = 1'b1;
        tick;
        total++; if ({ram_rd, ram_wr} !== 2'b10) begin bad++; $display("FAIL cr_c1_strobe got rd=%b wr=%b exp 1/0", ram_rd, ram_wr); end
        tick;
        total++; if (cpu_done !== 1'b0) begin bad++; $display("FAIL cr_c2_done got %b exp 0", cpu_done); end
        tick;
        total++; if ({cpu_done, cpu_out} !== {1'b1, 12'o7402}) begin bad++; $display("FAIL cr_c3 got done=%b out=%o exp 1 7402", cpu_done, cpu_out); end
        cpu_read_req = 1'b0;
        tick;
    endtask

    task automatic test_dma0_vs_cpu;
        dma0_write_req = 1'b1; dma0_ma = 15'o00200; dma0_in = 12'o1357;
        cpu_read_req = 1'b1; cpu_ma = 15'o00200;
        tick;
        total++; if ({grant, ram_wr} !== 4'b0011) begin bad++; $display("FAIL prio_c1 got grant=%b wr=%b exp 001/1", grant, ram_wr); end
        tick; tick;
        total++; if ({dma0_done, cpu_done} !== 2'b10) begin bad++; $display("FAIL prio_c3_done got dma0=%b cpu=%b exp 1/0", dma0_done, cpu_done); end
        dma0_write_req = 1'b0;
        tick;
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL prio_c4_idle got %b exp 000", grant); end
        tick;
        total++; if ({grant, ram_rd} !== 4'b1001) begin bad++; $display("FAIL prio_c5_cpu got grant=%b rd=%b exp 100/1", grant, ram_rd); end
        tick; tick;
        total++; if ({cpu_done, cpu_out} !== {1'b1, 12'o1357}) begin bad++; $display("FAIL prio_cpu_read got done=%b out=%o exp 1 1357", cpu_done, cpu_out); end
        cpu_read_req = 1'b0;
        tick;
    endtask

    task automatic test_burst;
        logic [2:0] exp_g;
        dma0_read_req = 1'b1; dma0_ma = 15'o00300;
        cpu_read_req = 1'b1;  cpu_ma = 15'o00200;
        d2_dma0_rd = 1'b1; d2_cpu_rd = 1'b1;
        for (int g = 0; g < 10; g++) begin
            exp_g = (g == 4 || g == 9) ? 3'b100 : 3'b001;
            tick;
            total++; if (grant !== exp_g) begin bad++; $display("FAIL burst_grant%0d got %b exp %b", g, grant, exp_g); end
            total++; if (d2_grant !== 3'b001) begin bad++; $display("FAIL noguard_grant%0d got %b exp 001", g, d2_grant); end
            repeat (3) tick;
        end
        dma0_read_req = 1'b0; cpu_read_req = 1'b0;
        d2_dma0_rd = 1'b0; d2_cpu_rd = 1'b0;
        tick;
        total++; if ({busy, d2_busy} !== 2'b00) begin bad++; $display("FAIL burst_end_idle got %b %b exp 0 0", busy, d2_busy); end
        total++; if (cpu_out !== 12'o1357) begin bad++; $display("FAIL burst_cpu_out got %o exp 1357", cpu_out); end
    endtask

    task automatic test_dma1_both;
        logic        d;
        logic [11:0] o;
        dma1_read_req = 1'b1; dma1_write_req = 1'b1; dma1_ma = 15'o10000; dma1_in = 12'o1234;
        tick;
        total++; if ({ram_wr, ram_rd, grant} !== 5'b10010) begin bad++; $display("FAIL both_c1 got wr=%b rd=%b grant=%b exp 1/0/010", ram_wr, ram_rd, grant); end
        total++; if ({ram_addr, ram_data_out} !== {15'o10000, 12'o1234}) begin bad++; $display("FAIL both_c1_bus got %o %o exp 10000 1234", ram_addr, ram_data_out); end
        tick;
        total++; if ({ram_wr, ram_rd} !== 2'b10) begin bad++; $display("FAIL both_c2 got wr=%b rd=%b exp 1/0", ram_wr, ram_rd); end
        tick;
        total++; if ({dma1_done, dma1_out} !== {1'b1, 12'o0}) begin bad++; $display("FAIL both_c3 got done=%b out=%o exp 1 0", dma1_done, dma1_out); end
        dma1_read_req = 1'b0; dma1_write_req = 1'b0;
        tick;
        run_access(1, 1'b0, 15'o10000, 12'o0, d, o);
        total++; if ({d, o} !== {1'b1, 12'o1234}) begin bad++; $display("FAIL both_readback got done=%b out=%o exp 1 1234", d, o); end
    endtask

    task automatic test_reset_mid;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        total++; if (cpu_out !== 12'o0) begin bad++; $display("FAIL rmid_pre_out got %o exp 0", cpu_out); end
        cpu_read_req = 1'b1; cpu_ma = 15'o00200;
        tick;
        tick;
        total++; if (ram_rd !== 1'b1) begin bad++; $display("FAIL rmid_c2_rd got %b exp 1", ram_rd); end
        reset = 1'b1;
        tick;
        reset = 1'b0; cpu_read_req = 1'b0;
        total++; if ({ram_rd, ram_wr, cpu_done} !== 3'b000) begin bad++; $display("FAIL rmid_c3 got rd=%b wr=%b done=%b exp 000", ram_rd, ram_wr, cpu_done); end
        total++; if ({grant, busy, cpu_out} !== 16'd0) begin bad++; $display("FAIL rmid_c3_state got grant=%b busy=%b out=%o exp 0", grant, busy, cpu_out); end
        tick;
        total++; if ({cpu_done, cpu_out} !== 13'd0) begin bad++; $display("FAIL rmid_c4 got done=%b out=%o exp 0 0", cpu_done, cpu_out); end
    endtask

    task automatic test_wrap;
        logic        d;
        logic [11:0] o;
        run_access(1, 1'b1, 15'o00000, 12'o1111, d, o);
        total++; if (d !== 1'b1) begin bad++; $display("FAIL wrap_w0_done got %b exp 1", d); end
        run_access(1, 1'b1, 15'o77777, 12'o5555, d, o);
        total++; if (d !== 1'b1) begin bad++; $display("FAIL wrap_wtop_done got %b exp 1", d); end
        run_access(1, 1'b0, 15'o77777, 12'o0, d, o);
        total++; if ({d, o} !== {1'b1, 12'o5555}) begin bad++; $display("FAIL wrap_rtop got done=%b out=%o exp 1 5555", d, o); end
        run_access(1, 1'b0, 15'o00000, 12'o0, d, o);
        total++; if ({d, o} !== {1'b1, 12'o1111}) begin bad++; $display("FAIL wrap_r0 got done=%b out=%o exp 1 1111", d, o); end
    endtask

    initial begin
        reset = 1'b1;
        {cpu_read_req, cpu_write_req, dma0_read_req, dma0_write_req, dma1_read_req, dma1_write_req} = '0;
        {d2_dma0_rd, d2_cpu_rd} = 2'b00;
        cpu_ma = '0; dma0_ma = '0; dma1_ma = '0;
        cpu_in = '0; dma0_in = '0; dma1_in = '0;
        test_reset;
        test_cpu_write_read;
        test_dma0_vs_cpu;
        test_burst;
        test_dma1_both;
        test_reset_mid;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
